// File: rtl/prompt_scheduler_pkg.sv
// Shared constants for the prompt overlay scheduler: layer indices, FSM encoding,
// default timing values and small one-hot / group-enable helpers.
package prompt_scheduler_pkg;

    localparam int NUM_REQ          = 6;
    localparam int IDX_W            = 3;
    localparam int MIN_FRAMES_DEF   = 30;
    localparam int BLINK_FRAMES_DEF = 16;
    localparam logic [9:0] V_EDGE_DEF = 10'd480;

    localparam int PR_Q1 = 0;
    localparam int PR_Q2 = 1;
    localparam int PR_Q3 = 2;
    localparam int PR_G1 = 3;
    localparam int PR_G2 = 4;
    localparam int PR_G3 = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SHOW    = 2'd2,
        ST_SWITCH  = 2'd3
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic quiz_of(input logic [NUM_REQ-1:0] oh);
        quiz_of = |oh[PR_Q3:PR_Q1];
    endfunction

    function automatic logic game_of(input logic [NUM_REQ-1:0] oh);
        game_of = |oh[PR_G3:PR_G1];
    endfunction

endpackage

// File: rtl/prompt_scheduler_frame_tick.sv
// Frame boundary detector: one-clk pulse when vCount enters V_EDGE, however long
// vCount then holds that value.
module prompt_scheduler_frame_tick
    import prompt_scheduler_pkg::*;
#(
    parameter logic [9:0] V_EDGE = V_EDGE_DEF
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_vcount,
    output logic       o_frame_tick
);

    logic [9:0] r_vcount_hist;

    // vCount history for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vcount_hist <= 10'd0;
        end else begin
            r_vcount_hist <= i_vcount;
        end
    end

    assign o_frame_tick = (r_vcount_hist != V_EDGE) && (i_vcount == V_EDGE);

endmodule

// File: rtl/prompt_scheduler.sv
// Prompt overlay scheduler: fixed-priority arbitration of six prompt layers with
// frame-aligned switching and a minimum on-screen time. Optional blink: PROMPT_BLINK_EN.
module prompt_scheduler
    import prompt_scheduler_pkg::*;
#(
    parameter int         MIN_FRAMES = MIN_FRAMES_DEF,
    parameter logic [9:0] V_EDGE     = V_EDGE_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         vCount,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] layer_en,
    output logic               quiz_en,
    output logic               game_en,
    output logic               shown,
    output logic               busy
);

    localparam int CNT_W = $clog2(MIN_FRAMES + 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_nxt;
    logic [IDX_W-1:0]   r_cur;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_layer_en;
    logic               r_quiz_en;
    logic               r_game_en;
    logic               r_shown;
    logic               r_busy;

    logic               w_frame_tick;
    logic               w_any;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_load_idx;
    logic [NUM_REQ-1:0] w_load_oh;
    logic               w_release;

    prompt_scheduler_frame_tick #(.V_EDGE(V_EDGE)) u_tick (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_vcount     (vCount),
        .o_frame_tick (w_frame_tick)
    );

    // Fixed-priority winner (lowest index) and the layer to load on a frame tick
    always_comb begin
        w_any = |req;
        w_win = {IDX_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_win = req[i] ? IDX_W'(i) : w_win;
        end
        w_sel      = req[r_nxt] ? r_nxt : w_win;
        w_load_idx = (r_state == ST_PENDING) ? w_sel : w_win;
        w_load_oh  = idx_to_onehot(w_load_idx);
        w_release  = (r_cnt == CNT_W'(MIN_FRAMES)) && (!req[r_cur] || (w_win != r_cur));
    end

`ifdef PROMPT_BLINK_EN
    localparam int BW = ($clog2(BLINK_FRAMES_DEF) > 0) ? $clog2(BLINK_FRAMES_DEF) : 1;
    logic [BW-1:0]      r_blink_cnt;
    logic               r_blink_on;
    logic [NUM_REQ-1:0] w_cur_oh;
    assign w_cur_oh = idx_to_onehot(r_cur);
`endif

    // Scheduler FSM with registered enables and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_nxt      <= {IDX_W{1'b0}};
            r_cur      <= {IDX_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_layer_en <= {NUM_REQ{1'b0}};
            r_quiz_en  <= 1'b0;
            r_game_en  <= 1'b0;
            r_shown    <= 1'b0;
            r_busy     <= 1'b0;
`ifdef PROMPT_BLINK_EN
            r_blink_cnt <= {BW{1'b0}};
            r_blink_on  <= 1'b1;
`endif
        end else begin
            r_shown <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_nxt   <= w_win;
                        r_state <= ST_PENDING;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (!req[r_nxt] && !w_any) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_frame_tick) begin
                        r_cur      <= w_load_idx;
                        r_layer_en <= w_load_oh;
                        r_quiz_en  <= quiz_of(w_load_oh);
                        r_game_en  <= game_of(w_load_oh);
                        r_cnt      <= {CNT_W{1'b0}};
                        r_shown    <= 1'b1;
                        r_state    <= ST_SHOW;
                        r_busy     <= 1'b0;
                    end else begin
                        r_nxt <= w_sel;
                    end
                end
                ST_SHOW: begin
                    if (w_frame_tick && (r_cnt != CNT_W'(MIN_FRAMES))) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`ifdef PROMPT_BLINK_EN
                    if (w_frame_tick) begin
                        if (r_blink_cnt == BW'(BLINK_FRAMES_DEF - 1)) begin
                            r_blink_cnt <= {BW{1'b0}};
                            r_blink_on  <= !r_blink_on;
                            r_layer_en  <= r_blink_on ? {NUM_REQ{1'b0}} : w_cur_oh;
                            r_quiz_en   <= r_blink_on ? 1'b0 : quiz_of(w_cur_oh);
                            r_game_en   <= r_blink_on ? 1'b0 : game_of(w_cur_oh);
                        end else begin
                            r_blink_cnt <= r_blink_cnt + BW'(1);
                        end
                    end
`endif
                    if (w_release) begin
                        r_state <= ST_SWITCH;
                        r_busy  <= 1'b1;
`ifdef PROMPT_BLINK_EN
                        // Leave SHOW in the on phase so the outgoing layer stays visible
                        r_layer_en <= w_cur_oh;
                        r_quiz_en  <= quiz_of(w_cur_oh);
                        r_game_en  <= game_of(w_cur_oh);
`endif
                    end
                end
                ST_SWITCH: begin
                    if (w_frame_tick) begin
                        if (w_any) begin
                            r_cur      <= w_load_idx;
                            r_layer_en <= w_load_oh;
                            r_quiz_en  <= quiz_of(w_load_oh);
                            r_game_en  <= game_of(w_load_oh);
                            r_cnt      <= {CNT_W{1'b0}};
                            r_shown    <= 1'b1;
                            r_state    <= ST_SHOW;
                        end else begin
                            r_layer_en <= {NUM_REQ{1'b0}};
                            r_quiz_en  <= 1'b0;
                            r_game_en  <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_layer_en <= {NUM_REQ{1'b0}};
                    r_quiz_en  <= 1'b0;
                    r_game_en  <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
`ifdef PROMPT_BLINK_EN
            if (r_state != ST_SHOW) begin
                r_blink_cnt <= {BW{1'b0}};
                r_blink_on  <= 1'b1;
            end
`endif
        end
    end

    assign layer_en = r_layer_en;
    assign quiz_en  = r_quiz_en;
    assign game_en  = r_game_en;
    assign shown    = r_shown;
    assign busy     = r_busy;

endmodule

// File: tb/tb_prompt_scheduler.sv
// Directed, table-driven bench for prompt_scheduler plus hand-written sequences
// for tick uniqueness and asynchronous reset.
module tb_prompt_scheduler;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] vCount = 10'd0;
    logic [5:0] req    = 6'd0;
    logic [5:0] layer_en;
    logic       quiz_en;
    logic       game_en;
    logic       shown;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int shown_cnt = 0;
    int tick_cnt = 0;

    typedef struct {
        logic [5:0] req;
        int         frames;
        logic [5:0] lay;
        logic       bsy;
        int         shw;
    } vec_t;

    vec_t vecs[$];

    prompt_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vCount   (vCount),
        .req      (req),
        .layer_en (layer_en),
        .quiz_en  (quiz_en),
        .game_en  (game_en),
        .shown    (shown),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (shown === 1'b1) shown_cnt++;
    always @(posedge clk) if (dut.w_frame_tick === 1'b1) tick_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame();
        @(negedge clk) vCount = 10'd479;
        @(negedge clk) vCount = 10'd480;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic [5:0] r, input int f, input logic [5:0] l, input logic b, input int s);
        vec_t v;
        v.req = r; v.frames = f; v.lay = l; v.bsy = b; v.shw = s;
        vecs.push_back(v);
    endtask

    initial begin
        int s0;
        int t0;

`ifdef PROMPT_BLINK_EN
        add(6'b000010,  0, 6'b000000, 1'b1, 0);
        add(6'b000010,  1, 6'b000010, 1'b0, 1);
        add(6'b000010, 15, 6'b000010, 1'b0, 0);
        add(6'b000010,  1, 6'b000000, 1'b0, 0);
        add(6'b000010, 14, 6'b000000, 1'b0, 0);
        add(6'b000010,  2, 6'b000010, 1'b0, 0);
        add(6'b000000,  0, 6'b000010, 1'b1, 0);
        add(6'b000000,  1, 6'b000000, 1'b0, 0);
`else
        // Q1 shown, dropped early, held for the minimum time, then released
        add(6'b000001,  0, 6'b000000, 1'b1, 0);
        add(6'b000001,  1, 6'b000001, 1'b0, 1);
        add(6'b000001,  5, 6'b000001, 1'b0, 0);
        add(6'b000000, 24, 6'b000001, 1'b0, 0);
        add(6'b000000,  1, 6'b000001, 1'b1, 0);
        add(6'b000000,  1, 6'b000000, 1'b0, 0);
        // G1 preempted by Q1 only after the minimum time, no blank frame
        add(6'b001000,  0, 6'b000000, 1'b1, 0);
        add(6'b001000,  1, 6'b001000, 1'b0, 1);
        add(6'b001000, 10, 6'b001000, 1'b0, 0);
        add(6'b001001, 19, 6'b001000, 1'b0, 0);
        add(6'b001001,  1, 6'b001000, 1'b1, 0);
        add(6'b001001,  1, 6'b000001, 1'b0, 1);
        // Same winner stays in SHOW without a re-show
        add(6'b000001, 30, 6'b000001, 1'b0, 0);
        add(6'b000011,  2, 6'b000001, 1'b0, 0);
        add(6'b000000,  1, 6'b000000, 1'b0, 0);
        // PENDING re-latch and abandon
        add(6'b000100,  0, 6'b000000, 1'b1, 0);
        add(6'b010000,  0, 6'b000000, 1'b1, 0);
        add(6'b010000,  1, 6'b010000, 1'b0, 1);
        add(6'b000000, 30, 6'b010000, 1'b1, 0);
        add(6'b000000,  1, 6'b000000, 1'b0, 0);
        add(6'b000100,  0, 6'b000000, 1'b1, 0);
        add(6'b000000,  0, 6'b000000, 1'b0, 0);
        add(6'b000000,  1, 6'b000000, 1'b0, 0);
`endif

        repeat (3) @(negedge clk);
        check("reset layer_en", 32'(layer_en), 32'd0);
        check("reset quiz_en",  32'(quiz_en),  32'd0);
        check("reset game_en",  32'(game_en),  32'd0);
        check("reset shown",    32'(shown),    32'd0);
        check("reset busy",     32'(busy),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            s0  = shown_cnt;
            req = vecs[i].req;
            if (vecs[i].frames == 0) begin
                @(negedge clk);
                @(negedge clk);
            end else begin
                for (int f = 0; f < vecs[i].frames; f++) run_frame();
            end
            check($sformatf("row%0d layer_en", i), 32'(layer_en), 32'(vecs[i].lay));
            check($sformatf("row%0d quiz_en", i),  32'(quiz_en),  32'(|vecs[i].lay[2:0]));
            check($sformatf("row%0d game_en", i),  32'(game_en),  32'(|vecs[i].lay[5:3]));
            check($sformatf("row%0d busy", i),     32'(busy),     32'(vecs[i].bsy));
            check($sformatf("row%0d shown", i),    32'(shown_cnt - s0), 32'(vecs[i].shw));
        end

        // vCount held at the edge value gives exactly one tick; re-entry gives another
        req = 6'd0;
        t0  = tick_cnt;
        @(negedge clk) vCount = 10'd479;
        @(negedge clk) vCount = 10'd480;
        repeat (1000) @(negedge clk);
        check("hold one tick", 32'(tick_cnt - t0), 32'd1);
        vCount = 10'd481;
        @(negedge clk) vCount = 10'd480;
        repeat (3) @(negedge clk);
        check("reentry second tick", 32'(tick_cnt - t0), 32'd2);

        // Asynchronous reset in SHOW, then G3 at the first new frame edge
        req = 6'b100000;
        @(negedge clk);
        run_frame();
        check("g3 before reset", 32'(layer_en), 32'h20);
        run_frame();
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("async layer_en", 32'(layer_en), 32'd0);
        check("async game_en",  32'(game_en),  32'd0);
        check("async busy",     32'(busy),     32'd0);
        vCount = 10'd100;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post-reset pending busy", 32'(busy), 32'd1);
        check("post-reset no layer",     32'(layer_en), 32'd0);
        s0 = shown_cnt;
        run_frame();
        check("post-reset g3 layer", 32'(layer_en), 32'h20);
        check("post-reset g3 game",  32'(game_en),  32'd1);
        check("post-reset g3 shown", 32'(shown_cnt - s0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prompt_scheduler.md
Name: prompt_scheduler

Overview:
- Sequences the six chained prompt overlay layers (quiz Q1–Q3, game G1–G3) that sit on top of the background VGA stream.
- Arbitrates level requests from the game/quiz FSM, keeps exactly one prompt layer visible at a time, and changes layers only at a frame boundary so the display never tears.
- Enforces a minimum on-screen time, and drives the per-layer and per-group enables that feed the overlay controller chain.

Parameters:
- NUM_REQ, 6, number of prompt layers; index 0–2 = Q1–Q3, 3–5 = G1–G3.
- MIN_FRAMES, 30, minimum number of frames a prompt stays visible once shown.
- V_EDGE, 10'd480, vCount value whose entry marks the frame boundary (start of vertical blank).
- BLINK_FRAMES, 16, half-period in frames for the optional blink.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- vCount  in  10  vertical pixel counter from the VGA timing generator; advances slower than clk.
- req  in  NUM_REQ  level prompt requests; bit i requests layer i.
- layer_en  out  NUM_REQ  one-hot or zero; enable for each overlay layer.
- quiz_en  out  1  OR of layer_en[2:0]; drives the shared quiz frame layers.
- game_en  out  1  OR of layer_en[5:3]; drives the shared game frame layers.
- shown  out  1  one-clk pulse when a new prompt first becomes visible.
- busy  out  1  high in PENDING and SWITCH.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; layer_en=0; quiz_en=0; game_en=0; shown=0; busy=0; frame counter=0; vCount history register=0.
- Frame edge:
  - frame_tick is a one-clk pulse when registered vCount ≠ V_EDGE and current vCount == V_EDGE.
  - Exactly one pulse per frame, even though vCount holds its value for many clk cycles.
- Winner: lowest set index of req (fixed priority; Q before G). cur = index of the layer currently shown.
- FSM:
  - IDLE: layer_en=0. If any req is set, latch the winner into nxt and go to PENDING.
  - PENDING:
    - If req[nxt] drops and no other req is set, return to IDLE.
    - If req[nxt] drops and another req is set, re-latch the new winner into nxt.
    - On frame_tick: cur←nxt; layer_en←onehot(nxt); frame counter←0; pulse shown; go to SHOW.
  - SHOW:
    - On each frame_tick, the frame counter increments and saturates at MIN_FRAMES.
    - Release condition: counter == MIN_FRAMES, and either req[cur]==0 or winner ≠ cur (higher priority pending). When it holds, go to SWITCH.
    - If req[cur] drops before MIN_FRAMES, the layer stays visible until MIN_FRAMES is reached.
  - SWITCH: layer_en is unchanged until the next frame_tick.
    - On frame_tick with a winner present: load it directly (cur←winner, layer_en←onehot, counter←0, pulse shown) and go to SHOW. No blank frame is inserted.
    - On frame_tick with no request: layer_en←0 and go to IDLE.
- Output timing:
  - layer_en changes only in the clk cycle after frame_tick; it is registered, with 1-clk latency from frame_tick.
  - quiz_en and game_en are registered together with layer_en.
- Preemption: a higher-priority request never cuts the MIN_FRAMES window short.
- Same-winner case: if the winner equals cur when the release condition is evaluated, the FSM stays in SHOW. No re-show occurs and shown does not pulse.
- Simultaneous events:
  - frame_tick in the same cycle that req changes: the FSM uses the req value sampled in that cycle.
  - rst_n asserted mid-frame: all outputs clear immediately.
  - After reset release, the first frame_tick requires a fresh vCount transition into V_EDGE.

Optional Feature:
- Macro: PROMPT_BLINK_EN.
- Defined: while in SHOW, the visible layer's layer_en bit (and its group enable) toggles every BLINK_FRAMES frame_ticks, starting in the on phase at show time.
  - The frame counter and MIN_FRAMES accounting are unaffected by blinking.
  - On leaving SHOW, the blink phase resets to on.
- Undefined: enables are steady; no blink counter is instantiated.

Decomposition:
- Shared package holds:
  - prompt index constants (PR_Q1=0 … PR_G3=5);
  - FSM state encoding (IDLE, PENDING, SHOW, SWITCH);
  - V_EDGE default.
- One sub-module is natural: frame_tick_gen (vCount history register plus edge compare). The priority encoder stays inline.

Test Plan:
- Reset, then req=6'b000001 → layer_en=000001 one clk after the next frame_tick; shown pulses once; quiz_en=1, game_en=0.
- req=000001 shown; drop req after 5 frames → layer_en holds until the counter reaches 30, clears at the following frame_tick, FSM returns to IDLE.
- req=001000 (G1) shown; at frame 10 raise req[0] → G1 stays until frame 30; at the next frame_tick layer_en=000001 with no blank frame; shown pulses.
- Hold vCount==480 for 1000 clks → exactly one frame_tick; vCount 481→480 again → second tick.
- rst_n low mid-SHOW → all outputs 0 asynchronously; after release with req=100000 → G3 is shown at the first new frame edge.
- PROMPT_BLINK_EN defined, req=000010 → layer_en[1] is on for 16 frames, off for 16, on again; release still happens at frame 30.
